// File: rtl/ram_stream_reader_if.sv
// Bundle of the start/status, RAM read port and output stream signals of
// ram_stream_reader. The master modport is the reader itself; the slave
// modport is the environment (RAM + controller + consumer).
interface ram_stream_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  // control / status
  logic                  start;
  logic                  busy;
  logic                  done;
  // synchronous-read RAM port
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  // output stream
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;

  modport master (
    input  start, rd_data, out_ready,
    output busy, done, rd_en, rd_addr,
    output out_valid, out_data, out_addr, out_last
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, done, rd_en, rd_addr,
    input  out_valid, out_data, out_addr, out_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Sweeps a synchronous-read RAM from address 0 to LAST_ADDR and streams each
// word (with its address and a last flag) onto a valid/ready channel. A
// 2-entry buffer hides the 1-cycle RAM latency so the stream sustains one
// word per cycle and resumes without a bubble after backpressure.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LAST_ADDR  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One extra bit on the issue address lets the sweep end cleanly even when
  // LAST_ADDR is the top of the address space.
  localparam logic [ADDR_WIDTH:0]   LAST_EXT = (ADDR_WIDTH+1)'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_A   = ADDR_WIDTH'(LAST_ADDR);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH:0]   r_next_addr;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_addr;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [ADDR_WIDTH-1:0] r_fifo_addr [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occupancy;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_last_hs;

  // Issue decision: only read when the buffer is guaranteed a free slot for
  // the word by the time it returns, counting the word popped this cycle.
  always_comb begin
    w_valid     = (r_count != 2'd0);
    w_pop       = w_valid & bus.out_ready;
    w_push      = r_inflight;
    w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue     = (r_state == S_RUN) && (r_next_addr <= LAST_EXT) &&
                  (w_occupancy < 3'd2);
    w_head_addr = r_fifo_addr[r_rd_ptr];
    w_head_data = r_fifo_data[r_rd_ptr];
    w_last_hs   = w_pop && (w_head_addr == LAST_A);
  end

  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = w_issue ? r_next_addr[ADDR_WIDTH-1:0] : '0;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? w_head_data : '0;
  assign bus.out_addr  = w_valid ? w_head_addr : '0;
  assign bus.out_last  = w_valid && (w_head_addr == LAST_A);
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // Sweep control: idle/run/done sequencing, busy/done flags, issue address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_next_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_next_addr <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_next_addr <= r_next_addr + 1'b1;
          end
          if (w_last_hs) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tracking and the 2-entry output buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_next_addr[ADDR_WIDTH-1:0];
      end
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.rd_data;
        r_fifo_addr[r_wr_ptr] <= r_inflight_addr;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // The issue rule must never let a returning word find the buffer full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a default instance (256 words) and
// a short instance (LAST_ADDR=3), each with its own RAM model and monitor.
module tb_ram_stream_reader;
  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int LAST_A = 255;
  localparam int LAST_B = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  ram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(LAST_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(LAST_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master));

  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];

  // synchronous-read RAM models
  always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= mem_a[bus_a.rd_addr];
  always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= mem_b[bus_b.rd_addr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard state ----------------
  word_t exp_a[$];
  word_t exp_b[$];
  int    iss_a = 0, pop_a = 0, dn_a = 0, exp_iss_a = 0;
  int    iss_b = 0, pop_b = 0, dn_b = 0, exp_iss_b = 0;
  bit    stall_a = 0, stall_b = 0;
  word_t held_a, held_b;

  // Expected stream: every address 0..LAST in order, data straight from RAM.
  task automatic push_a();
    for (int i = 0; i <= LAST_A; i++) exp_a.push_back('{AW'(i), mem_a[i], (i == LAST_A)});
  endtask
  task automatic push_b();
    for (int i = 0; i <= LAST_B; i++) exp_b.push_back('{AW'(i), mem_b[i], (i == LAST_B)});
  endtask
  task automatic clear_a();
    exp_a.delete(); iss_a = 0; pop_a = 0; exp_iss_a = 0;
  endtask
  task automatic clear_b();
    exp_b.delete(); iss_b = 0; pop_b = 0; exp_iss_b = 0;
  endtask

  // monitor A
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a = 0;
    end else begin
      word_t e;
      if (stall_a) begin
        chk("A_stall_valid", bus_a.out_valid, 1);
        chk("A_stall_data",  bus_a.out_data,  held_a.data);
        chk("A_stall_addr",  bus_a.out_addr,  held_a.addr);
        chk("A_stall_last",  bus_a.out_last,  held_a.last);
      end
      if (bus_a.rd_en) begin
        chk("A_rd_addr_seq", bus_a.rd_addr, exp_iss_a);
        exp_iss_a = (exp_iss_a == LAST_A) ? 0 : exp_iss_a + 1;
        iss_a++;
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        pop_a++;
        chk("A_word_expected", (exp_a.size() != 0), 1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          chk("A_out_addr", bus_a.out_addr, e.addr);
          chk("A_out_data", bus_a.out_data, e.data);
          chk("A_out_last", bus_a.out_last, e.last);
        end
      end
      chk("A_outstanding_le2", ((iss_a - pop_a) <= 2), 1);
      if (bus_a.done) begin
        dn_a++;
        chk("A_busy_low_in_done", bus_a.busy, 0);
      end
      stall_a = bus_a.out_valid && !bus_a.out_ready;
      held_a  = '{bus_a.out_addr, bus_a.out_data, bus_a.out_last};
    end
  end

  // monitor B
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_b = 0;
    end else begin
      word_t e;
      if (stall_b) begin
        chk("B_stall_valid", bus_b.out_valid, 1);
        chk("B_stall_data",  bus_b.out_data,  held_b.data);
        chk("B_stall_addr",  bus_b.out_addr,  held_b.addr);
      end
      if (bus_b.rd_en) begin
        chk("B_rd_addr_seq", bus_b.rd_addr, exp_iss_b);
        exp_iss_b = (exp_iss_b == LAST_B) ? 0 : exp_iss_b + 1;
        iss_b++;
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        pop_b++;
        chk("B_word_expected", (exp_b.size() != 0), 1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          chk("B_out_addr", bus_b.out_addr, e.addr);
          chk("B_out_data", bus_b.out_data, e.data);
          chk("B_out_last", bus_b.out_last, e.last);
        end
      end
      chk("B_outstanding_le2", ((iss_b - pop_b) <= 2), 1);
      if (bus_b.done) dn_b++;
      stall_b = bus_b.out_valid && !bus_b.out_ready;
      held_b  = '{bus_b.out_addr, bus_b.out_data, bus_b.out_last};
    end
  end

  // One sweep on instance A; k counts cycles after the start-accept edge.
  task automatic run_a(input bit rnd, input bit timing, input int p1, input int p2,
                       input int rst_at, input int budget, output int done_at);
    int vcnt;
    vcnt    = 0;
    done_at = 0;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      bus_a.start = (k == p1) || (k == p2);
      if (k == rst_at) rst_n = 1'b0;
      @(negedge clk);
      if (timing) begin
        if (k == 1) begin
          chk("A_c1_busy", bus_a.busy, 1);
          chk("A_c1_rd_en", bus_a.rd_en, 1);
          chk("A_c1_rd_addr", bus_a.rd_addr, 0);
        end
        if (k == 2) begin
          chk("A_c2_rd_addr", bus_a.rd_addr, 1);
          chk("A_c2_rd_data", bus_a.rd_data, mem_a[0]);
        end
        if (k == 3) begin
          chk("A_c3_valid", bus_a.out_valid, 1);
          chk("A_c3_data", bus_a.out_data, mem_a[0]);
        end
        if (bus_a.out_valid) vcnt++;
      end
      if (bus_a.done) begin
        done_at = k;
        break;
      end
      if (rst_at != 0 && k == rst_at + 1) begin
        chk("A_rst_busy", bus_a.busy, 0);
        chk("A_rst_done", bus_a.done, 0);
        chk("A_rst_rd_en", bus_a.rd_en, 0);
        chk("A_rst_rd_addr", bus_a.rd_addr, 0);
        chk("A_rst_valid", bus_a.out_valid, 0);
        chk("A_rst_data", bus_a.out_data, 0);
        chk("A_rst_addr", bus_a.out_addr, 0);
        chk("A_rst_last", bus_a.out_last, 0);
        break;
      end
      @(posedge clk); #1;
      if (rnd) bus_a.out_ready = 1'($urandom_range(0, 1));
    end
    bus_a.start = 1'b0;
    if (timing) chk("A_valid_cycles", vcnt, 256);
  endtask

  initial begin
    int d, d1, d2;
    bus_a.start = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("RST_A_busy", bus_a.busy, 0);
    chk("RST_A_done", bus_a.done, 0);
    chk("RST_A_rd_en", bus_a.rd_en, 0);
    chk("RST_A_rd_addr", bus_a.rd_addr, 0);
    chk("RST_A_valid", bus_a.out_valid, 0);
    chk("RST_A_data", bus_a.out_data, 0);
    chk("RST_A_addr", bus_a.out_addr, 0);
    chk("RST_A_last", bus_a.out_last, 0);
    chk("RST_B_valid", bus_b.out_valid, 0);
    chk("RST_B_rd_en", bus_b.rd_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full sweep, consumer always ready
    for (int i = 0; i < 256; i++) mem_a[i] = DW'(i * 3 + 7);
    clear_a(); push_a(); dn_a = 0;
    run_a(1'b0, 1'b1, 0, 0, 0, 300, d);
    chk("A_full_done_cycle", d, 259);
    @(posedge clk); #1;
    chk("A_full_done_count", dn_a, 1);
    chk("A_full_drained", exp_a.size(), 0);

    // random backpressure, random RAM contents
    for (int i = 0; i < 256; i++) mem_a[i] = $urandom;
    push_a(); dn_a = 0;
    run_a(1'b1, 1'b0, 0, 0, 0, 3000, d);
    bus_a.out_ready = 1'b1;
    chk("A_rand_done_seen", (d != 0), 1);
    @(posedge clk); #1;
    chk("A_rand_done_count", dn_a, 1);
    chk("A_rand_drained", exp_a.size(), 0);

    // start pulses while busy must be ignored
    push_a(); dn_a = 0;
    run_a(1'b0, 1'b0, 10, 100, 0, 300, d);
    chk("A_busy_start_done_cycle", d, 259);
    repeat (5) @(posedge clk);
    #1;
    chk("A_busy_start_done_count", dn_a, 1);
    chk("A_busy_start_drained", exp_a.size(), 0);

    // reset mid-sweep aborts with no done, next sweep restarts at 0
    push_a(); dn_a = 0;
    run_a(1'b0, 1'b0, 0, 0, 50, 300, d);
    chk("A_rst_mid_no_done_at", d, 0);
    @(posedge clk); #1;
    chk("A_rst_mid_done_count", dn_a, 0);
    rst_n = 1'b1;
    clear_a();
    @(posedge clk); #1;
    push_a(); dn_a = 0;
    run_a(1'b0, 1'b1, 0, 0, 0, 300, d);
    chk("A_resweep_done_cycle", d, 259);
    @(posedge clk); #1;
    chk("A_resweep_done_count", dn_a, 1);
    chk("A_resweep_drained", exp_a.size(), 0);

    // back-to-back sweeps with start held high
    push_a(); push_a(); dn_a = 0;
    d1 = 0; d2 = 0;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (d1 != 0) begin
        if (k == d1 + 1) begin
          chk("A_b2b_idle_busy", bus_a.busy, 0);
          chk("A_b2b_idle_rd_en", bus_a.rd_en, 0);
        end
        if (k == d1 + 2) begin
          chk("A_b2b_c1_busy", bus_a.busy, 1);
          chk("A_b2b_c1_rd_en", bus_a.rd_en, 1);
          chk("A_b2b_c1_rd_addr", bus_a.rd_addr, 0);
        end
        if (k == d1 + 4) begin
          chk("A_b2b_c3_valid", bus_a.out_valid, 1);
          chk("A_b2b_c3_data", bus_a.out_data, mem_a[0]);
        end
      end
      if (bus_a.done) begin
        if (d1 == 0) d1 = k;
        else begin
          d2 = k;
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus_a.start = 1'b0;
    chk("A_b2b_first_done", d1, 259);
    chk("A_b2b_second_done", d2, 519);
    @(posedge clk); #1;
    chk("A_b2b_done_count", dn_a, 2);
    chk("A_b2b_drained", exp_a.size(), 0);

    // short instance, consumer stalled until C10
    for (int i = 0; i < 256; i++) mem_b[i] = $urandom;
    clear_b(); push_b(); dn_b = 0;
    bus_b.out_ready = 1'b0;
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    d = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) bus_b.out_ready = 1'b1;
      @(negedge clk);
      if (k == 9) begin
        chk("B_issued_before_ready", iss_b, 2);
        chk("B_stalled_valid", bus_b.out_valid, 1);
        chk("B_stalled_head_addr", bus_b.out_addr, 0);
      end
      if (bus_b.done) begin
        d = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk("B_done_cycle", d, 14);
    @(posedge clk); #1;
    chk("B_done_count", dn_b, 1);
    chk("B_drained", exp_b.size(), 0);
    chk("B_total_issued", iss_b, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Streams the contents of a synchronous-read RAM, address 0 to `LAST_ADDR`, onto a valid/ready output channel. It is the drain counterpart of the ROM-to-RAM loader: once the loader has filled the RAM, this block reads every word back out in order. Consumers are the pixel/display pipeline and the bench checkers. A 2-entry output buffer absorbs the RAM's 1-cycle read latency and consumer backpressure. Sustained throughput is one word per cycle.

## Interface
- `ADDR_WIDTH`, default 8, RAM address width.
- `DATA_WIDTH`, default 32, RAM word width.
- `LAST_ADDR`, default 255, final address read; must be ≤ 2^ADDR_WIDTH−1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `start`  in  1  request a sweep; honoured only when idle.
- `busy`  out  1  high from the cycle after start acceptance until the `done` cycle.
- `done`  out  1  one-cycle pulse after the last word handshakes.
- `rd_en`  out  1  RAM read strobe.
- `rd_addr`  out  ADDR_WIDTH  RAM read address.
- `rd_data`  in  DATA_WIDTH  RAM data, valid the cycle after `rd_en`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts when high with `out_valid`.
- `out_data`  out  DATA_WIDTH  word read from RAM.
- `out_addr`  out  ADDR_WIDTH  address the word came from.
- `out_last`  out  1  high with the word from `LAST_ADDR`.

## Operation
- **States:**
  - IDLE → RUN when `start`=1.
  - RUN → DONE on the handshake of the `out_last` word.
  - DONE → IDLE unconditionally after 1 cycle.
  - `start` is ignored in RUN and DONE.
- **Counters:**
  - `next_addr` is the next address to issue, cleared to 0 on start acceptance.
  - An in-flight flag marks a read issued last cycle.
  - A FIFO count 0..2 tracks the buffered words.
- **Read issue:** `rd_en` is high only when all of the following hold:
  - state is RUN;
  - `next_addr` has not yet passed `LAST_ADDR`;
  - count + inflight − (`out_valid` & `out_ready`) < 2.
- **Issue side effects:**
  - `rd_addr`=`next_addr` whenever `rd_en`=1.
  - `next_addr` increments on each issue.
  - No wrap: after `LAST_ADDR` is issued, `rd_en` stays low for the rest of the sweep. Width of the increment is ADDR_WIDTH+1, to detect passing 2^ADDR_WIDTH−1.
- **FIFO and output:**
  - A word whose in-flight flag is set is pushed into the FIFO with its address at the next edge.
  - `out_valid` = count≠0.
  - `out_data`, `out_addr` and `out_last` present the FIFO head.
  - `out_last` = (head address == `LAST_ADDR`).
  - Push and pop in the same cycle leave the count unchanged.
  - The FIFO never overflows; the issue rule guarantees this, and an assertion checks it.
- **Stall:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_addr` and `out_last` hold stable.
- **Reset (`rst_n`=0 at an edge):**
  - State goes to IDLE; the count and in-flight flag clear.
  - Any pending `rd_data` is discarded.
  - Outputs go to: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0.
  - Reset mid-sweep aborts the sweep with no `done`.

## Timing
- **Start acceptance:** `start` is sampled at edge E0 while IDLE.
- **Startup latency, with `out_ready`=1 throughout:**
  - C1 (after E0): `busy`=1, `rd_en`=1, `rd_addr`=0.
  - C2: `rd_data`=mem[0] and `rd_addr`=1.
  - C3: `out_valid`=1, `out_data`=mem[0]. First-word latency is 3 cycles.
- **Steady state:** with `out_ready`=1, `out_valid` stays high for LAST_ADDR+1 consecutive cycles, with addresses incrementing by 1.
- **Completion:**
  - `done`=1 the cycle after the `out_last` handshake; `busy` is 0 in that same cycle.
  - For the defaults, `done` falls in cycle C259 after E0.
  - `start` asserted during the `done` cycle is ignored; it is accepted from the next cycle.
- **Backpressure recovery:** after `out_ready` returns high, valid data resumes with no bubble; the 2 buffered words cover the read latency.

## Test plan
- **Full sweep:** RAM preloaded mem[i]=i*3+7, `out_ready`=1 → 256 words in order, matching data and address. `out_valid` is continuous from C3 to C258, `out_last` only at address 255, `done` at C259.
- **Random backpressure:** `out_ready` 50% random → same 256 words, none lost or duplicated. Outputs hold stable during every stall, and the FIFO count never exceeds 2.
- **Start while busy:** `start` pulsed at C10 and C100 → no restart; `rd_addr` sequence is unaffected and exactly one `done` is produced.
- **Reset mid-sweep:** `rst_n`=0 at C50 → all outputs 0 the next cycle with no `done`. A subsequent `start` sweeps again from address 0.
- **Short instance:** `LAST_ADDR`=3, `out_ready` held low until C10 → at most 2 reads outstanding before C10. After that, addresses 0..3 are delivered and `rd_addr` never exceeds 3.
- **Back-to-back sweeps:** `start` held high continuously → second sweep accepted the cycle after `done`, with its first word 3 cycles later.
